// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional single-cycle multiplier: define MULDIV_FAST_MUL_EN.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL,
    OP_MULU,
    OP_DIV,
    OP_DIVU
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    MUL1
  } state_e;

  localparam int MULDIV_ITER = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitude
// on accept and for sign fixup of results.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit mul/div with start/busy handshake and HI/LO result.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mul_start,
  input  logic             mulu_start,
  input  logic             div_start,
  input  logic             divu_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e state;
  op_e    op;
  op_e    op_sel;

  logic start_q;
  logic any_start;
  logic accept;
  logic mul_sel;
  logic sgn_sel;
  logic op_mul;
  logic sign_q;
  logic sign_r;
  logic b_zero;
  logic unused;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opd;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_mul;
  logic [2*WIDTH-1:0] acc_div;
  logic [2*WIDTH-1:0] prod_in;
  logic [2*WIDTH-1:0] prod;

  assign any_start = mul_start | mulu_start
                   | div_start | divu_start;
  assign accept = any_start & ~start_q
                & (state == IDLE) & ~rst;
  assign busy = (state != IDLE) | accept;

  always_comb begin
    op_sel = OP_MULU;
    priority case (1'b1)
      div_start:  op_sel = OP_DIV;
      divu_start: op_sel = OP_DIVU;
      mul_start:  op_sel = OP_MUL;
      default:    op_sel = OP_MULU;
    endcase
  end

  assign mul_sel = (op_sel == OP_MUL) | (op_sel == OP_MULU);
  assign sgn_sel = (op_sel == OP_MUL) | (op_sel == OP_DIV);
  assign op_mul  = (op == OP_MUL) | (op == OP_MULU);

  muldiv_negate #(.W(WIDTH)) u_abs_a (
    .neg (sgn_sel & a[WIDTH-1]),
    .x   (a),
    .y   (abs_a)
  );

  muldiv_negate #(.W(WIDTH)) u_abs_b (
    .neg (sgn_sel & b[WIDTH-1]),
    .x   (b),
    .y   (abs_b)
  );

  // Shift-add: multiplier sits in acc low half, product grows from the top.
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + (acc[0] ? {1'b0, opd} : '0);
  assign acc_mul = {msum, acc[WIDTH-1:1]};

  // Restoring divide: remainder in acc high half, quotient shifts into low.
  assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff = {1'b0, shifted} - {2'b0, opd};
  assign acc_div = diff[WIDTH+1]
    ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
    : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign unused = diff[WIDTH];

`ifdef MULDIV_FAST_MUL_EN
  assign prod_in = (state == MUL1)
    ? ({{WIDTH{1'b0}}, opd} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]})
    : acc;
`else
  assign prod_in = acc;
`endif

  muldiv_negate #(.W(2*WIDTH)) u_fix_p (
    .neg (sign_q),
    .x   (prod_in),
    .y   (prod)
  );

  muldiv_negate #(.W(WIDTH)) u_fix_q (
    .neg (sign_q),
    .x   (acc[WIDTH-1:0]),
    .y   (quo)
  );

  muldiv_negate #(.W(WIDTH)) u_fix_r (
    .neg (sign_r),
    .x   (acc[2*WIDTH-1:WIDTH]),
    .y   (rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= OP_MUL;
      cnt     <= '0;
      start_q <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      opd     <= '0;
      acc     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      b_zero  <= 1'b0;
    end else begin
      start_q <= any_start;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op     <= op_sel;
            cnt    <= '0;
            sign_q <= sgn_sel & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r <= sgn_sel & a[WIDTH-1];
            b_zero <= (b == '0);
            if (mul_sel) begin
              opd <= abs_a;
              acc <= {{WIDTH{1'b0}}, abs_b};
            end else begin
              opd <= abs_b;
              acc <= {{WIDTH{1'b0}}, abs_a};
            end
`ifdef MULDIV_FAST_MUL_EN
            state <= mul_sel ? MUL1 : RUN;
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          acc <= op_mul ? acc_mul : acc_div;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (op_mul) begin
            {hi, lo} <= prod;
          end else begin
            lo <= b_zero ? DIV0_QUOTIENT : quo;
            hi <= rem;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        MUL1: begin
          {hi, lo} <= prod;
          done     <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
